// File: rtl/elliptic_curve_structs.sv
// Curve-level types shared by the MSM datapath and its batch loader.
package elliptic_curve_structs;

  localparam int P_WIDTH      = 256;
  localparam int SCALAR_WIDTH = 256;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  typedef enum logic [1:0] {LD_LOAD, LD_PAD, LD_RUN} loader_state_t;

endpackage

// File: rtl/msm_batch_loader.sv
// Packs streamed (point, scalar) pairs into msm_naive G/x arrays, zero-pads short batches, runs the MSM.
// Launch one cycle after a full batch (plus one per pad slot); in_ready only while loading.
module msm_batch_loader
  import elliptic_curve_structs::*;
#(
  parameter int LENGTH = 100
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [P_WIDTH-1:0]            in_x,
  input  logic [P_WIDTH-1:0]            in_y,
  input  logic [SCALAR_WIDTH-1:0]       in_scalar,
  input  logic                          in_last,
  output curve_point_t                  G [LENGTH],
  output logic [SCALAR_WIDTH-1:0]       x [LENGTH],
  output logic                          msm_rst,
  input  logic                          msm_done,
  output logic                          batch_done,
  output logic [$clog2(LENGTH+1)-1:0]   count
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  loader_state_t state;
  logic [CW-1:0] idx;       // load count in LOAD, pad slot in PAD
  logic          run_armed; // low on the first RUN cycle, when Done may still be stale
  logic          xfer;

  assign in_ready = (state == LD_LOAD);
  assign xfer     = in_valid & in_ready;
  assign count    = idx;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= LD_LOAD;
      idx        <= '0;
      msm_rst    <= 1'b1;
      batch_done <= 1'b0;
      run_armed  <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        LD_LOAD: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state     <= LD_RUN;
              msm_rst   <= 1'b0;
              run_armed <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
              if (in_last) state <= LD_PAD;
            end
          end
        end
        LD_PAD: begin
          if (idx == LAST_IDX) begin
            state     <= LD_RUN;
            msm_rst   <= 1'b0;
            run_armed <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        LD_RUN: begin
          if (!run_armed) begin
            run_armed <= 1'b1;
          end else if (msm_done) begin
            state      <= LD_LOAD;
            idx        <= '0;
            msm_rst    <= 1'b1;
            batch_done <= 1'b1;
          end
        end
        default: begin
          state   <= LD_LOAD;
          idx     <= '0;
          msm_rst <= 1'b1;
        end
      endcase
    end
  end

  // Array storage is deliberately unreset; every slot is rewritten before the next launch.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      if (xfer) begin
        G[idx[AW-1:0]] <= '{x: in_x, y: in_y};
        x[idx[AW-1:0]] <= in_scalar;
      end else if (state == LD_PAD) begin
        G[idx[AW-1:0]] <= '0;
        x[idx[AW-1:0]] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_msm_batch_loader.sv
// Scoreboard bench for msm_batch_loader at LENGTH=4; the bench plays the MSM's Done handshake.
module tb_msm_batch_loader;
  import elliptic_curve_structs::*;

  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  typedef struct packed {
    curve_point_t                g;
    logic [SCALAR_WIDTH-1:0]     s;
  } slot_t;

  logic                      clk = 1'b0;
  logic                      Reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [P_WIDTH-1:0]        in_x = '0;
  logic [P_WIDTH-1:0]        in_y = '0;
  logic [SCALAR_WIDTH-1:0]   in_scalar = '0;
  logic                      in_last = 1'b0;
  curve_point_t              G [L];
  logic [SCALAR_WIDTH-1:0]   xs [L];
  logic                      msm_rst;
  logic                      msm_done = 1'b0;
  logic                      batch_done;
  logic [CW-1:0]             count;

  slot_t                     exp_q[$];
  curve_point_t              snap_g [L];
  logic [SCALAR_WIDTH-1:0]   snap_x [L];
  int                        checks = 0;
  int                        errors = 0;

  msm_batch_loader #(.LENGTH(L)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_scalar(in_scalar), .in_last(in_last),
    .G(G), .x(xs), .msm_rst(msm_rst), .msm_done(msm_done),
    .batch_done(batch_done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic drive_pair(input bit last);
    slot_t e;
    int    w = 0;
    e.g.x = rand256();
    e.g.y = rand256();
    e.s   = rand256();
    in_valid = 1'b1; in_x = e.g.x; in_y = e.g.y; in_scalar = e.s; in_last = last;
    while (!in_ready && w < 100) begin tick(); w++; end
    if (w == 100) check("ready_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic load_batch(input int n, input bit use_last, input bit done_noise);
    for (int i = 0; i < n; i++) begin
      if (done_noise) msm_done = 1'b1;
      drive_pair(use_last && (i == n - 1));
      if (i < L - 1 && !(use_last && i == n - 1)) check("count_step", count, i + 1);
    end
    msm_done = 1'b0;
  endtask

  // Pads the scoreboard, measures launch latency, then compares every slot.
  task automatic wait_run(input int n);
    slot_t z = '0;
    slot_t e;
    int    lat = 1;
    for (int k = n; k < L; k++) exp_q.push_back(z);
    while (msm_rst === 1'b1 && lat < 40) begin tick(); lat++; end
    check("launch_latency", lat, 1 + L - n);
    check("ready_at_launch", in_ready, 1'b0);
    for (int i = 0; i < L; i++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1'b0, 1'b1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("G[%0d]", i), G[i], e.g);
        check($sformatf("x[%0d]", i), xs[i], e.s);
      end
      snap_g[i] = G[i];
      snap_x[i] = xs[i];
    end
  endtask

  // Called on the first RUN cycle: stale Done, back-pressure, then real Done.
  task automatic finish_run();
    msm_done = 1'b1;
    in_valid = 1'b1; in_x = rand256(); in_y = rand256(); in_scalar = rand256(); in_last = 1'b1;
    tick();
    msm_done = 1'b0;
    check("stale_done_ignored", msm_rst, 1'b0);
    check("no_early_batch_done", batch_done, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ready_low_in_run", in_ready, 1'b0);
    end
    for (int i = 0; i < L; i++) begin
      check($sformatf("G_frozen[%0d]", i), G[i], snap_g[i]);
      check($sformatf("x_frozen[%0d]", i), xs[i], snap_x[i]);
    end
    in_valid = 1'b0; in_last = 1'b0;
    msm_done = 1'b1;
    tick();
    msm_done = 1'b0;
    check("batch_done_pulse", batch_done, 1'b1);
    check("rearm_msm_rst", msm_rst, 1'b1);
    check("rearm_ready", in_ready, 1'b1);
    check("rearm_count", count, 0);
    tick();
    check("batch_done_one_cycle", batch_done, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", in_ready, 1'b1);
    check("rst_msm_rst", msm_rst, 1'b1);
    check("rst_count", count, 0);
    check("rst_batch_done", batch_done, 1'b0);
    Reset = 1'b0;

    // full batch, last on final beat
    load_batch(L, 1'b1, 1'b0);
    wait_run(L);
    finish_run();

    // short batch of 2 with Done noise while loading
    load_batch(2, 1'b1, 1'b1);
    wait_run(2);
    finish_run();

    // single pair batch
    load_batch(1, 1'b1, 1'b0);
    wait_run(1);
    finish_run();

    // implicit close; finish_run offers a fifth pair that must be refused
    load_batch(L, 1'b0, 1'b0);
    wait_run(L);
    finish_run();

    // reset mid-LOAD
    load_batch(2, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    check("midload_rst_count", count, 0);
    check("midload_rst_msm_rst", msm_rst, 1'b1);
    check("midload_rst_ready", in_ready, 1'b1);
    Reset = 1'b0;
    exp_q.delete();

    // reset mid-RUN
    load_batch(L, 1'b1, 1'b0);
    wait_run(L);
    tick();
    Reset = 1'b1;
    tick();
    check("midrun_rst_count", count, 0);
    check("midrun_rst_msm_rst", msm_rst, 1'b1);
    check("midrun_rst_ready", in_ready, 1'b1);
    Reset = 1'b0;
    exp_q.delete();

    // fresh batch after reset
    load_batch(L, 1'b1, 1'b0);
    wait_run(L);
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
